// File: rtl/cpu_pkg.sv
// Shared pipeline constants and stage-entry type for the hazard scoreboard.
// Holds the forward-select encodings, the Tuse/Tnew constants, the MDU latencies
// and the small helpers used to age and qualify stage entries.
package cpu_pkg;

    // D-operand forward select
    localparam logic [3:0] JUDGE_NONE = 4'd0;
    localparam logic [3:0] JUDGE_E    = 4'd1;   // PC+8 of a jal sitting in E
    localparam logic [3:0] JUDGE_M    = 4'd2;
    localparam logic [3:0] JUDGE_W    = 4'd3;

    // E-operand forward select
    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;

    // Tuse of 3 marks an operand the instruction does not read
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew measured at E entry
    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Multiply/divide unit busy time
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int MD_CNT_W    = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
        logic       regwrite;
        logic [1:0] tnew;
        logic       isjal;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    // A stage only counts as a producer when it writes a register other than $0
    function automatic logic is_live(input logic regwrite, input logic [4:0] wreg);
        return regwrite && (wreg != 5'd0);
    endfunction

    // One pipeline step closer to having the result: saturate at zero
    function automatic logic [1:0] age_tnew(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Hazard match for one D-stage source operand against the E/M/W producers.
// Picks the youngest live producer of the operand's register and reports the
// forward select plus whether the value cannot arrive in time (stall request).
module hazard_match
    import cpu_pkg::*;
(
    input  logic [4:0] src,
    input  logic [1:0] tuse,
    input  logic       e_live,
    input  logic [4:0] e_wreg,
    input  logic [1:0] e_tnew,
    input  logic       m_live,
    input  logic [4:0] m_wreg,
    input  logic [1:0] m_tnew,
    input  logic       w_live,
    input  logic [4:0] w_wreg,
    output logic [3:0] select,
    output logic       stall_req
);

    logic e_hit;
    logic m_hit;
    logic w_hit;
    logic used;

    assign e_hit = e_live && (e_wreg == src);
    assign m_hit = m_live && (m_wreg == src);
    assign w_hit = w_live && (w_wreg == src);
    assign used  = (tuse != TUSE_NONE);

    // Youngest matching producer wins; an unfinished result selects nothing and may stall
    always_comb begin
        select    = JUDGE_NONE;
        stall_req = 1'b0;
        if (e_hit) begin
            if (e_tnew == 2'd0) select = JUDGE_E;
            stall_req = used && (e_tnew > tuse);
        end else if (m_hit) begin
            if (m_tnew == 2'd0) select = JUDGE_M;
            stall_req = used && (m_tnew > tuse);
        end else if (w_hit) begin
            select = JUDGE_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for a 5-stage MIPS-style pipeline.
// Tracks the producer in E, M and W, drives D- and E-stage forward selects and
// the D hold / E bubble stall. Optional MDU busy tracking is built when the
// macro SCOREBOARD_MDU_EN is defined.
module hazard_scoreboard
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_wreg,
    input  logic       D_regwrite,
    input  logic [1:0] D_tnew,
    input  logic       D_isjal,
`ifdef SCOREBOARD_MDU_EN
    input  logic       D_is_md,
    input  logic       E_md_start,
    input  logic       E_md_isdiv,
`endif
    output logic       stall,
    output logic [3:0] DRD1Judge,
    output logic [3:0] DRD2Judge,
    output logic [1:0] EFwdA,
    output logic [1:0] EFwdB,
    output logic       Eisjal,
    output logic       Misjal
);

    stage_t e_stage;
    stage_t m_stage;
    stage_t w_stage;
    stage_t d_entry;
    stage_t m_next;
    stage_t w_next;

    logic e_live;
    logic m_live;
    logic w_live;
    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic unused_fields;

    // E-operand select: M only once its result exists, otherwise W
    function automatic logic [1:0] e_fwd_sel(
        input logic [4:0] src,
        input logic       m_ok,
        input logic [4:0] m_wreg,
        input logic [1:0] m_tnew,
        input logic       w_ok,
        input logic [4:0] w_wreg
    );
        if (m_ok && (m_wreg == src)) return (m_tnew == 2'd0) ? FWD_M : FWD_NONE;
        if (w_ok && (w_wreg == src)) return FWD_W;
        return FWD_NONE;
    endfunction

    // Pack the D-stage fields and form the aged entries for M and W
    always_comb begin
        d_entry          = STAGE_BUBBLE;
        d_entry.rs       = D_rs;
        d_entry.rt       = D_rt;
        d_entry.wreg     = D_wreg;
        d_entry.regwrite = D_regwrite;
        d_entry.tnew     = D_tnew;
        d_entry.isjal    = D_isjal;
        m_next           = e_stage;
        m_next.tnew      = age_tnew(e_stage.tnew);
        w_next           = m_stage;
        w_next.tnew      = 2'd0;
    end

    // Stage registers: a stall drops a bubble into E while M and W keep moving
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_stage <= STAGE_BUBBLE;
            m_stage <= STAGE_BUBBLE;
            w_stage <= STAGE_BUBBLE;
        end else begin
            e_stage <= stall ? STAGE_BUBBLE : d_entry;
            m_stage <= m_next;
            w_stage <= w_next;
        end
    end

    assign e_live = is_live(e_stage.regwrite, e_stage.wreg);
    assign m_live = is_live(m_stage.regwrite, m_stage.wreg);
    assign w_live = is_live(w_stage.regwrite, w_stage.wreg);

    hazard_match u_match_rs (
        .src       (D_rs),
        .tuse      (D_tuse_rs),
        .e_live    (e_live),
        .e_wreg    (e_stage.wreg),
        .e_tnew    (e_stage.tnew),
        .m_live    (m_live),
        .m_wreg    (m_stage.wreg),
        .m_tnew    (m_stage.tnew),
        .w_live    (w_live),
        .w_wreg    (w_stage.wreg),
        .select    (DRD1Judge),
        .stall_req (rs_stall)
    );

    hazard_match u_match_rt (
        .src       (D_rt),
        .tuse      (D_tuse_rt),
        .e_live    (e_live),
        .e_wreg    (e_stage.wreg),
        .e_tnew    (e_stage.tnew),
        .m_live    (m_live),
        .m_wreg    (m_stage.wreg),
        .m_tnew    (m_stage.tnew),
        .w_live    (w_live),
        .w_wreg    (w_stage.wreg),
        .select    (DRD2Judge),
        .stall_req (rt_stall)
    );

    assign EFwdA = e_fwd_sel(e_stage.rs, m_live, m_stage.wreg, m_stage.tnew, w_live, w_stage.wreg);
    assign EFwdB = e_fwd_sel(e_stage.rt, m_live, m_stage.wreg, m_stage.tnew, w_live, w_stage.wreg);

    assign Eisjal = e_stage.isjal;
    assign Misjal = m_stage.isjal;

`ifdef SCOREBOARD_MDU_EN
    logic [MD_CNT_W-1:0] md_count;

    // MDU busy counter: reload on a start in E, then count down to idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_count <= '0;
        end else if (E_md_start) begin
            md_count <= E_md_isdiv ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        end else if (md_count != '0) begin
            md_count <= md_count - MD_CNT_W'(1);
        end
    end

    // The start input is live during reset, so gate it to keep stall low
    assign md_stall = reset && D_is_md && (E_md_start || (md_count != '0));
`else
    assign md_stall = 1'b0;
`endif

    assign stall = rs_stall | rt_stall | md_stall;

    // Fields carried for a complete stage record but not read by any hazard rule
    assign unused_fields = ^{m_stage.rs, m_stage.rt, w_stage.rs, w_stage.rt,
                             w_stage.tnew, w_stage.isjal};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios followed by
// randomized instruction streams, compared against an age-based reference model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_tuse_rs;
    logic [1:0] D_tuse_rt;
    logic [4:0] D_wreg;
    logic       D_regwrite;
    logic [1:0] D_tnew;
    logic       D_isjal;
    logic       stall;
    logic [3:0] DRD1Judge;
    logic [3:0] DRD2Judge;
    logic [1:0] EFwdA;
    logic [1:0] EFwdB;
    logic       Eisjal;
    logic       Misjal;
`ifdef SCOREBOARD_MDU_EN
    logic       D_is_md;
    logic       E_md_start;
    logic       E_md_isdiv;
`endif

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_wreg     (D_wreg),
        .D_regwrite (D_regwrite),
        .D_tnew     (D_tnew),
        .D_isjal    (D_isjal),
`ifdef SCOREBOARD_MDU_EN
        .D_is_md    (D_is_md),
        .E_md_start (E_md_start),
        .E_md_isdiv (E_md_isdiv),
`endif
        .stall      (stall),
        .DRD1Judge  (DRD1Judge),
        .DRD2Judge  (DRD2Judge),
        .EFwdA      (EFwdA),
        .EFwdB      (EFwdB),
        .Eisjal     (Eisjal),
        .Misjal     (Misjal)
    );

    // Reference model: the last three issued instructions, index = cycles since E entry
    typedef struct {
        int rs;
        int rt;
        int wreg;
        int regwrite;
        int tnew;
        int isjal;
    } ent_t;

    ent_t hist [3];
    int   md_busy = 0;

    function automatic ent_t mk(input int rs, input int rt, input int wreg,
                                input int rw, input int tnew, input int jal);
        ent_t e;
        e.rs = rs; e.rt = rt; e.wreg = wreg;
        e.regwrite = rw; e.tnew = tnew; e.isjal = jal;
        return e;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d", phase, tag, got, exp);
        end
    endtask

    // Cycles remaining until an instruction of the given age has its result
    function automatic int remaining(input int k);
        int tn;
        if (k == 2) return 0;
        tn = hist[k].tnew - k;
        return (tn < 0) ? 0 : tn;
    endfunction

    function automatic int produces(input int k, input int r);
        return (hist[k].regwrite != 0 && hist[k].wreg != 0 && hist[k].wreg == r) ? 1 : 0;
    endfunction

    function automatic void d_expect(input int r, input int tuse, output int sel, output int stl);
        sel = 0;
        stl = 0;
        for (int k = 0; k < 3; k++) begin
            if (produces(k, r) != 0) begin
                sel = (remaining(k) == 0) ? k + 1 : 0;
                stl = (tuse != 3 && remaining(k) > tuse) ? 1 : 0;
                return;
            end
        end
    endfunction

    function automatic int e_expect(input int r);
        for (int k = 1; k < 3; k++) begin
            if (produces(k, r) != 0) return (remaining(k) == 0) ? k : 0;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = mk(0, 0, 0, 0, 0, 0);
        md_busy = 0;
    endtask

    // One clock of D-stage stimulus: check outputs mid-cycle, then advance the model
    task automatic step(input ent_t d, input int tuse_rs, input int tuse_rt,
                        input int is_md, input int md_start, input int md_div,
                        output int obs_stall);
        int s1, s2, j1, j2, exp_stall;
        D_rs       = 5'(d.rs);
        D_rt       = 5'(d.rt);
        D_wreg     = 5'(d.wreg);
        D_regwrite = 1'(d.regwrite);
        D_tnew     = 2'(d.tnew);
        D_isjal    = 1'(d.isjal);
        D_tuse_rs  = 2'(tuse_rs);
        D_tuse_rt  = 2'(tuse_rt);
`ifdef SCOREBOARD_MDU_EN
        D_is_md    = 1'(is_md);
        E_md_start = 1'(md_start);
        E_md_isdiv = 1'(md_div);
`endif
        @(negedge clk);
        d_expect(d.rs, tuse_rs, j1, s1);
        d_expect(d.rt, tuse_rt, j2, s2);
        exp_stall = s1 | s2;
`ifdef SCOREBOARD_MDU_EN
        if (is_md != 0 && (md_start != 0 || md_busy != 0)) exp_stall = 1;
`endif
        check("stall",     int'(stall),     exp_stall);
        check("DRD1Judge", int'(DRD1Judge), j1);
        check("DRD2Judge", int'(DRD2Judge), j2);
        check("EFwdA",     int'(EFwdA),     e_expect(hist[0].rs));
        check("EFwdB",     int'(EFwdB),     e_expect(hist[0].rt));
        check("Eisjal",    int'(Eisjal),    hist[0].isjal);
        check("Misjal",    int'(Misjal),    hist[1].isjal);
        obs_stall = int'(stall);
        @(posedge clk);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (exp_stall != 0) ? mk(0, 0, 0, 0, 0, 0) : d;
        if (md_start != 0) md_busy = (md_div != 0) ? 10 : 5;
        else if (md_busy > 0) md_busy--;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"},  int'(stall),     0);
        check({tag, ".DRD1"},   int'(DRD1Judge), 0);
        check({tag, ".DRD2"},   int'(DRD2Judge), 0);
        check({tag, ".EFwdA"},  int'(EFwdA),     0);
        check({tag, ".EFwdB"},  int'(EFwdB),     0);
        check({tag, ".Eisjal"}, int'(Eisjal),    0);
        check({tag, ".Misjal"}, int'(Misjal),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   obs;
        int   n_stall;
        ent_t nop;
        ent_t d;

        nop = mk(0, 0, 0, 0, 0, 0);
        model_reset();
        reset      = 1'b0;
        D_rs       = 5'd1;
        D_rt       = 5'd1;
        D_tuse_rs  = 2'd0;
        D_tuse_rt  = 2'd0;
        D_wreg     = 5'd1;
        D_regwrite = 1'b1;
        D_tnew     = 2'd2;
        D_isjal    = 1'b1;
`ifdef SCOREBOARD_MDU_EN
        D_is_md    = 1'b0;
        E_md_start = 1'b0;
        E_md_isdiv = 1'b0;
`endif

        // Reset state, including across clock edges with live D inputs
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        check_all_zero("rst");
        reset = 1'b1;

        // Load followed by a dependent ALU op: one stall, then W forwarding into E
        phase = "load_use";
        step(mk(0, 0, 1, 1, 2, 0), 3, 3, 0, 0, 0, obs);
        check("first_no_stall", obs, 0);
        step(mk(1, 3, 2, 1, 1, 0), 1, 1, 0, 0, 0, obs);
        check("stall_cycle", obs, 1);
        step(mk(1, 3, 2, 1, 1, 0), 1, 1, 0, 0, 0, obs);
        check("released", obs, 0);
        step(nop, 3, 3, 0, 0, 0, obs);
        check("after", obs, 0);
        step(nop, 3, 3, 0, 0, 0, obs);

        // jal then beq $31,$0: PC+8 from E, no stall
        phase = "jal_beq";
        step(mk(0, 0, 31, 1, 0, 1), 3, 3, 0, 0, 0, obs);
        step(mk(31, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, obs);
        check("no_stall", obs, 0);
        step(nop, 3, 3, 0, 0, 0, obs);
        step(nop, 3, 3, 0, 0, 0, obs);

        // Two writers of $5 in flight: the younger one in E wins and stalls
        phase = "youngest";
        step(mk(0, 0, 5, 1, 1, 0), 3, 3, 0, 0, 0, obs);
        step(mk(0, 0, 5, 1, 1, 0), 3, 3, 0, 0, 0, obs);
        step(mk(5, 0, 6, 1, 1, 0), 0, 3, 0, 0, 0, obs);
        check("e_stall", obs, 1);
        step(nop, 3, 3, 0, 0, 0, obs);
        step(nop, 3, 3, 0, 0, 0, obs);

        // Writers of $0 in every stage never forward or stall
        phase = "reg0";
        step(mk(0, 0, 0, 1, 2, 0), 3, 3, 0, 0, 0, obs);
        step(mk(0, 0, 0, 1, 2, 0), 3, 3, 0, 0, 0, obs);
        step(mk(0, 0, 0, 1, 2, 0), 3, 3, 0, 0, 0, obs);
        step(mk(0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, obs);
        check("no_stall", obs, 0);

        // Reset asserted while a stall is active clears everything without a clock
        phase = "reset_mid_stall";
        step(mk(0, 0, 1, 1, 2, 0), 3, 3, 0, 0, 0, obs);
        D_rs       = 5'd1;
        D_rt       = 5'd0;
        D_tuse_rs  = 2'd1;
        D_tuse_rt  = 2'd3;
        D_wreg     = 5'd0;
        D_regwrite = 1'b0;
        D_tnew     = 2'd0;
        D_isjal    = 1'b0;
        @(negedge clk);
        check("pre_stall", int'(stall), 1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async");
        @(posedge clk);
        #1;
        check_all_zero("held");
        reset = 1'b1;
        model_reset();

`ifdef SCOREBOARD_MDU_EN
        // Divide start in E with mfhi in D: stalls through the whole busy window
        phase = "mdu_div";
        n_stall = 0;
        step(nop, 3, 3, 1, 1, 1, obs);
        n_stall += obs;
        for (int i = 0; i < 20 && obs != 0; i++) begin
            step(nop, 3, 3, 1, 0, 0, obs);
            n_stall += obs;
        end
        check("stall_cycles", n_stall, 11);
`endif

        // Random instruction streams over a small register set to provoke hazards
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            d = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 5) == 0) ? 1 : 0);
            step(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 11) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)), obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
